// File: rtl/pong_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pong_pkg
// Description : Shared definitions for the pong pipeline: ball FSM state
//               encoding, direction encoding and the default grid geometry
//               used by the paddle, ball and display stages.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package pong_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      MOVE = 2'd1,
      MISS = 2'd2
   } state_e;

   // Direction of travel on either axis. For Y, "positive" is downwards.
   localparam logic DIR_POS = 1'b0;
   localparam logic DIR_NEG = 1'b1;

   // Default grid geometry shared with the paddle stage and the display.
   localparam int GRID_COL_BITS = 3;
   localparam int GRID_ROW_BITS = 3;
   localparam int PADDLE_SIZE   = 2;

endpackage : pong_pkg
`default_nettype wire

// File: rtl/ball_engine_tick_divider.sv
`default_nettype none
// ============================================================================
// Module      : tick_divider
// Description : Free-running modulo-TICK_DIV counter with synchronous clear.
//               Emits a one-cycle step pulse on the cycle the count equals
//               TICK_DIV-1 and wraps to 0 on that same cycle.
// Ports       : clk     - system clock
//               rst     - synchronous active-high reset
//               clear_i - holds the counter at 0 (no pulse) while high
//               step_o  - one-cycle step pulse
// Revision    : 1.0 - initial release
// ============================================================================
module tick_divider #(
   parameter int TICK_DIV = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic clear_i,
   output logic step_o
);

   localparam int            CW   = $clog2(TICK_DIV);
   localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d  = cnt_q;
      step_o = 1'b0;
      if (clear_i) begin
         cnt_d = '0;
      end else if (cnt_q == LAST) begin
         cnt_d  = '0;
         step_o = 1'b1;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

endmodule : tick_divider
`default_nettype wire

// File: rtl/ball_engine.sv
`default_nettype none
// ============================================================================
// Module      : ball_engine
// Description : Steps a ball across a 2**BIT_WIDTH x 2**ROW_BITS grid at a
//               prescaled rate, reflecting off the side and top walls and
//               bouncing off the paddle on the bottom row.
// Ports       : clk, rst     - clock, synchronous active-high reset
//               en           - game enable; low parks the ball in IDLE
//               serve        - launches the ball from IDLE or MISS
//               paddle_left  - paddle left column
//               ball_x/y     - registered ball position
//               hit / miss   - one-cycle pulses on paddle bounce / miss
//               playing      - high while the ball is moving
//               score        - saturating hits since last serve
// Revision    : 1.0 - initial release
// ============================================================================
module ball_engine
   import pong_pkg::*;
#(
   parameter int BIT_WIDTH  = GRID_COL_BITS,
   parameter int ROW_BITS   = GRID_ROW_BITS,
   parameter int SIZE       = PADDLE_SIZE,
   parameter int START_X    = 4,
   parameter int TICK_DIV   = 4,
   parameter int SCORE_BITS = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  serve,
   input  logic [BIT_WIDTH-1:0]  paddle_left,
   output logic [BIT_WIDTH-1:0]  ball_x,
   output logic [ROW_BITS-1:0]   ball_y,
   output logic                  hit,
   output logic                  miss,
   output logic                  playing,
   output logic [SCORE_BITS-1:0] score
);

   localparam logic [BIT_WIDTH-1:0] X_MAX   = '1;
   localparam logic [BIT_WIDTH-1:0] X_START = BIT_WIDTH'(START_X);
   localparam logic [ROW_BITS-1:0]  Y_LAST  = '1;               // paddle row
   localparam logic [ROW_BITS-1:0]  Y_PRE   = Y_LAST - 1'b1;    // row above paddle
   localparam logic [ROW_BITS-1:0]  Y_BOUNCE = Y_LAST - 2'd2;   // row after a hit
   localparam logic [ROW_BITS-1:0]  Y_ONE   = ROW_BITS'(1);

   state_e                  state_q, state_d;
   logic [BIT_WIDTH-1:0]    x_q, x_d;
   logic [ROW_BITS-1:0]     y_q, y_d;
   logic                    dx_q, dx_d;
   logic                    dy_q, dy_d;
   logic [SCORE_BITS-1:0]   score_q, score_d;
   logic                    hit_q, hit_d;
   logic                    miss_q, miss_d;

   logic                    step;
   logic [BIT_WIDTH-1:0]    nx;
   logic                    ndx;
   logic                    catch_w;
   logic [BIT_WIDTH:0]      nx_ext, pl_lo, pl_hi;

   // Counter only runs while moving; dropping en also stops it immediately
   // so a step can never coincide with the return to IDLE.
   tick_divider #(.TICK_DIV(TICK_DIV)) u_tick (
      .clk     (clk),
      .rst     (rst),
      .clear_i (!en || (state_q != MOVE)),
      .step_o  (step)
   );

   // Next column, reflecting off the side walls.
   always_comb begin
      ndx = dx_q;
      if (dx_q == DIR_POS) begin
         if (x_q == X_MAX) begin
            ndx = DIR_NEG;
            nx  = x_q - 1'b1;
         end else begin
            nx  = x_q + 1'b1;
         end
      end else begin
         if (x_q == '0) begin
            ndx = DIR_POS;
            nx  = x_q + 1'b1;
         end else begin
            nx  = x_q - 1'b1;
         end
      end
   end

   // Paddle test in one extra bit so paddle_left+SIZE cannot wrap.
   always_comb begin
      nx_ext  = {1'b0, nx};
      pl_lo   = {1'b0, paddle_left};
      pl_hi   = pl_lo + (BIT_WIDTH+1)'(SIZE);
      catch_w = (nx_ext >= pl_lo) && (nx_ext <= pl_hi);
   end

   // Next-state and datapath.
   always_comb begin
      state_d = state_q;
      x_d     = x_q;
      y_d     = y_q;
      dx_d    = dx_q;
      dy_d    = dy_q;
      score_d = score_q;
      hit_d   = 1'b0;
      miss_d  = 1'b0;
      if (!en) begin
         state_d = IDLE;
         x_d     = X_START;
         y_d     = '0;
         dx_d    = DIR_POS;
         dy_d    = DIR_POS;
      end else begin
         case (state_q)
            IDLE: begin
               x_d  = X_START;
               y_d  = '0;
               dx_d = DIR_POS;
               dy_d = DIR_POS;
               if (serve) begin
                  state_d = MOVE;
                  score_d = '0;
               end
            end
            MOVE: begin
               if (step) begin
                  x_d  = nx;
                  dx_d = ndx;
                  if ((dy_q == DIR_NEG) && (y_q == '0)) begin
                     dy_d = DIR_POS;
                     y_d  = Y_ONE;
                  end else if ((dy_q == DIR_POS) && (y_q == Y_PRE)) begin
                     if (catch_w) begin
                        dy_d  = DIR_NEG;
                        y_d   = Y_BOUNCE;
                        hit_d = 1'b1;
                        if (score_q != '1) score_d = score_q + 1'b1;
                     end else begin
                        y_d     = Y_LAST;
                        miss_d  = 1'b1;
                        state_d = MISS;
                     end
                  end else if (dy_q == DIR_POS) begin
                     y_d = y_q + 1'b1;
                  end else begin
                     y_d = y_q - 1'b1;
                  end
               end
            end
            MISS: begin
               if (serve) begin
                  state_d = MOVE;
                  score_d = '0;
                  x_d     = X_START;
                  y_d     = '0;
                  dx_d    = DIR_POS;
                  dy_d    = DIR_POS;
               end
            end
            default: begin
               state_d = IDLE;
               x_d     = X_START;
               y_d     = '0;
               dx_d    = DIR_POS;
               dy_d    = DIR_POS;
            end
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         x_q     <= X_START;
         y_q     <= '0;
         dx_q    <= DIR_POS;
         dy_q    <= DIR_POS;
         score_q <= '0;
         hit_q   <= 1'b0;
         miss_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         x_q     <= x_d;
         y_q     <= y_d;
         dx_q    <= dx_d;
         dy_q    <= dy_d;
         score_q <= score_d;
         hit_q   <= hit_d;
         miss_q  <= miss_d;
      end
   end

   // Outputs.
   always_comb begin
      ball_x  = x_q;
      ball_y  = y_q;
      hit     = hit_q;
      miss    = miss_q;
      score   = score_q;
      playing = (state_q == MOVE);
   end

endmodule : ball_engine
`default_nettype wire

// File: tb/tb_ball_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_ball_engine
// Description : Scoreboard bench for ball_engine. A driver applies stimulus
//               on the falling edge, advances a behavioural game model and
//               queues the expected outputs; a monitor pops and compares
//               after every rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ball_engine;

   localparam int BW = 3, RB = 3, SZ = 2, SX = 4, TD = 4, SB = 4;
   localparam int W = 1 << BW, H = 1 << RB, SCORE_MAX = (1 << SB) - 1;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          en = 1'b1;
   logic          serve = 1'b0;
   logic [BW-1:0] paddle_left = '0;
   logic [BW-1:0] ball_x;
   logic [RB-1:0] ball_y;
   logic          hit, miss, playing;
   logic [SB-1:0] score;

   ball_engine #(
      .BIT_WIDTH(BW), .ROW_BITS(RB), .SIZE(SZ),
      .START_X(SX), .TICK_DIV(TD), .SCORE_BITS(SB)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .serve(serve), .paddle_left(paddle_left),
      .ball_x(ball_x), .ball_y(ball_y), .hit(hit), .miss(miss),
      .playing(playing), .score(score)
   );

   always #5 clk = ~clk;

   typedef struct {
      int x, y, hit, miss, playing, score;
   } exp_t;

   exp_t exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;

   // Behavioural game model: positions as integers, directions as +1/-1.
   int m_state;  // 0 parked, 1 moving, 2 missed
   int m_x, m_y, m_dx, m_dy, m_wait, m_score, m_hit, m_miss;

   task automatic park();
      m_x = SX; m_y = 0; m_dx = 1; m_dy = 1;
   endtask

   task automatic model_cycle(input bit r, input bit e, input bit s, input int pl);
      int nx, ny;
      m_hit = 0; m_miss = 0;
      if (r) begin
         park(); m_state = 0; m_wait = 0; m_score = 0;
      end else if (!e) begin
         park(); m_state = 0; m_wait = 0;
      end else if (m_state == 0) begin
         park(); m_wait = 0;
         if (s) begin m_state = 1; m_score = 0; end
      end else if (m_state == 2) begin
         m_wait = 0;
         if (s) begin park(); m_state = 1; m_score = 0; end
      end else if (m_wait < TD - 1) begin
         m_wait++;
      end else begin
         m_wait = 0;
         nx = m_x + m_dx;
         if (nx < 0 || nx > W - 1) begin m_dx = -m_dx; nx = m_x + m_dx; end
         ny = m_y + m_dy;
         if (ny < 0) begin
            m_dy = 1; ny = 1;
         end else if (m_dy == 1 && m_y == H - 2) begin
            if (nx >= pl && nx <= pl + SZ) begin
               m_hit = 1; m_dy = -1; ny = H - 3;
               m_score = (m_score < SCORE_MAX) ? m_score + 1 : SCORE_MAX;
            end else begin
               m_miss = 1; ny = H - 1; m_state = 2;
            end
         end
         m_x = nx; m_y = ny;
      end
   endtask

   task automatic drive(input bit r, input bit e, input bit s, input int pl);
      exp_t ex;
      @(negedge clk);
      rst = r; en = e; serve = s; paddle_left = BW'(pl);
      model_cycle(r, e, s, pl);
      ex.x = m_x; ex.y = m_y; ex.hit = m_hit; ex.miss = m_miss;
      ex.playing = (m_state == 1) ? 1 : 0; ex.score = m_score;
      exp_q.push_back(ex);
   endtask

   task automatic run(input int n, input bit e, input int pl);
      for (int i = 0; i < n; i++) drive(1'b0, e, 1'b0, pl);
   endtask

   // Monitor: one comparison per rising edge that has an expectation queued.
   initial begin
      exp_t ex;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            ex = exp_q.pop_front();
            vectors++;
            if (int'(ball_x) != ex.x || int'(ball_y) != ex.y || int'(hit) != ex.hit ||
                int'(miss) != ex.miss || int'(playing) != ex.playing || int'(score) != ex.score) begin
               miscompares++;
               $display("FAIL outputs @%0t: got x=%0d y=%0d hit=%0d miss=%0d play=%0d score=%0d, want x=%0d y=%0d hit=%0d miss=%0d play=%0d score=%0d",
                        $time, ball_x, ball_y, hit, miss, playing, score,
                        ex.x, ex.y, ex.hit, ex.miss, ex.playing, ex.score);
            end
         end
      end
   end

   initial begin
      int pl;
      m_state = 0; m_wait = 0; m_score = 0; m_hit = 0; m_miss = 0; park();

      // Reset, then parked idle.
      drive(1'b1, 1'b1, 1'b0, 0);
      drive(1'b1, 1'b1, 1'b0, 0);
      run(20, 1'b1, 0);

      // Serve, right-wall bounce, paddle hit at left=2, climb to the top.
      drive(1'b0, 1'b1, 1'b1, 2);
      run(80, 1'b1, 2);

      // Enable drop, then enable low with serve held.
      drive(1'b0, 1'b0, 1'b0, 2);
      drive(1'b0, 1'b0, 1'b1, 2);
      drive(1'b0, 1'b0, 1'b1, 2);
      run(3, 1'b1, 2);

      // Serve and miss with paddle at 5, frozen, re-serve from MISS.
      drive(1'b0, 1'b1, 1'b1, 5);
      run(50, 1'b1, 5);
      drive(1'b0, 1'b1, 1'b1, 5);
      run(14, 1'b1, 5);

      // Reset pulse mid-flight.
      drive(1'b1, 1'b1, 1'b0, 5);
      run(5, 1'b1, 5);

      // Tracking paddle: every return is caught, score must saturate.
      drive(1'b0, 1'b1, 1'b1, 3);
      for (int i = 0; i < 900; i++) begin
         pl = (m_x > 0) ? m_x - 1 : 0;
         drive(1'b0, 1'b1, 1'b0, pl);
      end
      @(posedge clk);
      #2;
      vectors++;
      if (score !== SB'(SCORE_MAX)) begin
         miscompares++;
         $display("FAIL score_sat: got %0d, want %0d", score, SCORE_MAX);
      end

      // Randomised play.
      for (int i = 0; i < 4000; i++) begin
         drive(($urandom_range(0, 199) == 0), ($urandom_range(0, 29) != 0),
               ($urandom_range(0, 7) == 0), int'($urandom_range(0, W - 1)));
      end

      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule : tb_ball_engine
`default_nettype wire

// File: doc/ball_engine.md
Name: ball_engine

Overview:
- Ball-motion stage directly downstream of the paddle-position register.
- Consumes the paddle's left-column position and steps a ball across a WIDTH x HEIGHT cell grid at a prescaled rate.
- Ball reflects off the side and top walls and bounces off the paddle on the bottom row.
- Reports hits, misses and a score to the display and score logic.

Parameters:
- BIT_WIDTH, 3, column index width; grid is 2**BIT_WIDTH columns.
- ROW_BITS, 3, row index width; grid is 2**ROW_BITS rows; row 0 is top, row 2**ROW_BITS-1 is the paddle row.
- SIZE, 2, paddle spans columns paddle_left .. paddle_left+SIZE inclusive.
- START_X, 4, serve column.
- TICK_DIV, 4, clk cycles per ball step (>=2).
- SCORE_BITS, 4, score width.

Ports:
- clk  in  1  system clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- en  in  1  game enable; low parks the ball.
- serve  in  1  level; launches the ball from IDLE or MISS.
- paddle_left  in  BIT_WIDTH  paddle left column from the paddle stage.
- ball_x  out  BIT_WIDTH  ball column.
- ball_y  out  ROW_BITS  ball row.
- hit  out  1  one-cycle pulse on paddle bounce.
- miss  out  1  one-cycle pulse on entering the paddle row uncaught.
- playing  out  1  high in MOVE.
- score  out  SCORE_BITS  hits since last serve, saturating.

Behaviour:
- Reset (rst high at posedge), and the next cycle:
  - ball_x=START_X, ball_y=0, dx=+1, dy=down.
  - State IDLE; tick counter 0.
  - score=0, hit=0, miss=0, playing=0.
  - rst overrides everything, including mid-MOVE.
- States:
  - IDLE: ball parked at (START_X,0) with dx=+1, dy=down. en&&serve -> MOVE, score cleared.
  - MOVE: steps the ball. Miss -> MISS.
  - MISS: ball frozen in the paddle row. en&&serve -> re-park and go to MOVE in the same transition, score cleared.
  - en low in any state -> IDLE next cycle. en low beats serve. score is held until the next serve.
- Tick:
  - Counter runs only in MOVE and is cleared in every other state.
  - A step occurs on the cycle the counter equals TICK_DIV-1; the counter wraps to 0 on that cycle.
  - First step is therefore TICK_DIV cycles after entering MOVE.
- Step, X axis:
  - If (dx=+1 and x=max) or (dx=-1 and x=0): flip dx and move one column in the new direction.
  - Otherwise move x by dx.
- Step, Y axis:
  - Moving up at y=0: flip to down and set y=1.
  - Moving down at y=HEIGHT-2: compute next x first, then test next_x against [paddle_left, paddle_left+SIZE].
    - Compare in BIT_WIDTH+1 bits so there is no wrap.
    - paddle_left is sampled on the step cycle.
  - Inside the range (hit):
    - dy flips to up, y becomes HEIGHT-3, x becomes next_x.
    - hit pulses for that single cycle.
    - score increments, saturating at all-ones.
  - Outside the range (miss):
    - y becomes HEIGHT-1, x becomes next_x.
    - miss pulses; state becomes MISS.
  - Otherwise move y by dy.
- Both axes are evaluated on the same step, so a corner flips both directions.
- Outputs are registered: ball_x/ball_y update on the step-cycle edge, coincident with hit/miss.
- hit and miss are never high together, and are 0 outside step cycles.

Decomposition:
- Shared package pong_pkg holds:
  - State encoding: IDLE=2'd0, MOVE=2'd1, MISS=2'd2.
  - Direction constants: DIR_POS=1'b0, DIR_NEG=1'b1.
  - Default grid constants shared with the paddle stage and display.
- One natural sub-module, tick_divider: counter with clear input and one-cycle step pulse out.
- The remaining FSM and datapath live in ball_engine.

Test Plan (defaults):
- Reset: rst high 2 cycles, en=1, serve=0 -> ball (4,0), playing=0, score=0, no pulses; stays parked for 20 cycles.
- Serve and side wall: serve=1 one cycle -> playing=1. Steps every 4 cycles: (5,1),(6,2),(7,3), then right-wall bounce to (6,4), then (5,5),(4,6).
- Paddle hit: continue the serve trace with paddle_left=2. Next step -> (3,5), hit=1 for exactly 1 cycle, score=1, dy up. Further steps reach the top: y=0 then y=1, dy down.
- Paddle miss: same trace with paddle_left=5 -> (3,7), miss=1 for 1 cycle, state MISS, ball frozen 20 cycles. serve=1 -> (4,0), score=0, MOVE.
- Enable drop and simultaneous serve: en=0 mid-MOVE -> IDLE next cycle, ball (4,0), score held. en=0 with serve=1 -> stays IDLE.
- Reset mid-flight: rst pulse during MOVE at (6,4) -> next cycle (4,0), IDLE, score=0, counter=0. Separately, 16 consecutive hits -> score saturates at 15.
